// File: rtl/cordic_vec_pkg.sv
// rtl/cordic_vec_pkg.sv - shared CORDIC constants: angle table, gain inverse, 90-degree code, FSM states
package cordic_vec_pkg;

    localparam logic [15:0] CORDIC_GAIN_INV = 16'hDBD9;
    localparam logic [23:0] PH90            = 24'h800000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MAG  = 2'd2,
        DONE = 2'd3
    } state_t;

    // atan(2^-(i+1)) with 90 deg = 2^23
    function automatic logic [22:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    return 23'h25C80A;
            5'd1:    return 23'h13F671;
            5'd2:    return 23'h0A2224;
            5'd3:    return 23'h051617;
            5'd4:    return 23'h028BB0;
            5'd5:    return 23'h0145EC;
            5'd6:    return 23'h00A2F9;
            5'd7:    return 23'h00517D;
            5'd8:    return 23'h0028BE;
            5'd9:    return 23'h00145F;
            5'd10:   return 23'h000A30;
            5'd11:   return 23'h000518;
            5'd12:   return 23'h00028C;
            5'd13:   return 23'h000146;
            5'd14:   return 23'h0000A3;
            5'd15:   return 23'h000051;
            5'd16:   return 23'h000029;
            5'd17:   return 23'h000014;
            5'd18:   return 23'h00000A;
            default: return 23'h000000;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_if.sv
// rtl/cordic_vec_if.sv - input-pair and result handshake bundle for cordic_vec
interface cordic_vec_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] phase;
    logic [16:0] mag;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, phase, mag
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, phase, mag
    );

endinterface

// File: rtl/cordic_vec.sv
// rtl/cordic_vec.sv - iterative vectoring CORDIC, (x,y) to quarter phase; CORDIC_MAG_EN adds magnitude
module cordic_vec
    import cordic_vec_pkg::*;
#(
    parameter int ITERS = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    cordic_vec_if.slave bus
);

    state_t             state, next_state;
    logic [4:0]         iter;
    logic signed [19:0] xr, yr;
    logic [23:0]        pr;
    logic               f_zero, f_xzero, f_yzero;
    logic               ready_q, valid_q;
    logic [15:0]        phase_q, phase_c;

    logic               accept, last_step;
    logic signed [19:0] x_ext, y_ext, x_sh, y_sh;
    logic [23:0]        ang;

    assign accept    = bus.in_valid && ready_q;
    assign last_step = (iter == 5'(ITERS - 1));
    assign x_ext     = signed'({2'b00, bus.x, 2'b00});
    assign y_ext     = signed'({2'b00, bus.y, 2'b00});
    assign x_sh      = xr >>> (iter + 5'd1);
    assign y_sh      = yr >>> (iter + 5'd1);
    assign ang       = {1'b0, atan_lut(iter)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = RUN;
            RUN: begin
                if (last_step) begin
`ifdef CORDIC_MAG_EN
                    next_state = MAG;
`else
                    next_state = DONE;
`endif
                end
            end
            MAG:  next_state = DONE;
            DONE: if (valid_q && bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pre-rotation folds the 45..90 deg half onto -45..0 so the table's range suffices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr      <= '0;
            yr      <= '0;
            pr      <= '0;
            iter    <= '0;
            f_zero  <= 1'b0;
            f_xzero <= 1'b0;
            f_yzero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        iter    <= '0;
                        f_zero  <= (bus.x == 16'h0) && (bus.y == 16'h0);
                        f_xzero <= (bus.x == 16'h0);
                        f_yzero <= (bus.y == 16'h0);
                        if (bus.y > bus.x) begin
                            xr <= y_ext;
                            yr <= -x_ext;
                            pr <= PH90;
                        end else begin
                            xr <= x_ext;
                            yr <= y_ext;
                            pr <= '0;
                        end
                    end
                end
                RUN: begin
                    iter <= iter + 5'd1;
                    if (!yr[19]) begin
                        xr <= xr + y_sh;
                        yr <= yr - x_sh;
                        pr <= pr + ang;
                    end else begin
                        xr <= xr - y_sh;
                        yr <= yr + x_sh;
                        pr <= pr - ang;
                    end
                end
                default: ;
            endcase
        end
    end

    // pr only strays slightly outside 0..90 deg: top bits 11 = just below 0, 10 = at/above 90
    always_comb begin
        phase_c = pr[22:7];
        if (f_zero || f_yzero)     phase_c = 16'h0000;
        else if (f_xzero)          phase_c = 16'hFFFF;
        else if (pr[23:22] == 2'b11) phase_c = 16'h0000;
        else if (pr[23:22] == 2'b10) phase_c = 16'hFFFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            phase_q <= '0;
        end else begin
            ready_q <= (next_state == IDLE);
            if (state == DONE) begin
                if (!valid_q) begin
                    valid_q <= 1'b1;
                    phase_q <= phase_c;
                end else if (bus.out_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.phase     = phase_q;

`ifdef CORDIC_MAG_EN
    logic [16:0] mag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            mag_q <= '0;
        else if (state == MAG) mag_q <= f_zero ? 17'h0 :
            17'((34'(xr[18:2]) * 34'(CORDIC_GAIN_INV)) >> 16);
    end

    assign bus.mag = mag_q;
`else
    assign bus.mag = 17'h0;
`endif

endmodule
